// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder plus hard-decision Viterbi decoder; independent tx and rx halves.
// Latency: encoder 1 cycle; decoder TB_DEPTH-1 accepted symbols plus 1 register stage.
// Backpressure: none; each side takes one item per cycle its enable is high, with no wait states.
module viterbi_codec #(
    parameter int TB_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_i,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_o,
    input  logic       dec_enable_i,
    input  logic [1:0] dec_d_i,
    output logic       dec_valid_o,
    output logic       dec_d_o
);

    localparam int               CNT_W   = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_VLD = CNT_W'(TB_DEPTH - 1);

    // Symbol emitted from state s for input d: {G1 = 111, G0 = 101}.
    function automatic logic [1:0] code_sym(input logic d, input logic [1:0] s);
        return {d ^ s[1] ^ s[0], d ^ s[0]};
    endfunction

    function automatic logic [7:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {6'd0, x[1] & x[0], x[1] ^ x[0]};
    endfunction

    // ---------------- encoder ----------------
    logic [1:0] enc_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_state   <= 2'b00;
            enc_d_o     <= 2'b00;
            enc_valid_o <= 1'b0;
        end else begin
            enc_valid_o <= enc_enable_i;
            if (enc_enable_i) begin
                enc_d_o   <= code_sym(enc_d_i, enc_state);
                enc_state <= {enc_d_i, enc_state[1]};
            end
        end
    end

    // ---------------- decoder ----------------
    logic [7:0]          pm       [4];
    logic [TB_DEPTH-1:0] surv     [4];
    logic [7:0]          cand0    [4];
    logic [7:0]          cand1    [4];
    logic                sel      [4];
    logic [7:0]          acs_pm   [4];
    logic [7:0]          pm_nxt   [4];
    logic [TB_DEPTH-1:0] surv_nxt [4];
    logic [7:0]          pm_min;
    logic [1:0]          best;
    logic [CNT_W-1:0]    sym_cnt;

    // Next state n = {d, a} is reached from {a,0} or {a,1}; ties keep {a,0}.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cand0[n]    = pm[{n[0], 1'b0}] + hamming(dec_d_i, code_sym(n[1], {n[0], 1'b0}));
            cand1[n]    = pm[{n[0], 1'b1}] + hamming(dec_d_i, code_sym(n[1], {n[0], 1'b1}));
            sel[n]      = cand1[n] < cand0[n];
            acs_pm[n]   = sel[n] ? cand1[n] : cand0[n];
            surv_nxt[n] = {sel[n] ? surv[{n[0], 1'b1}][TB_DEPTH-2:0]
                                  : surv[{n[0], 1'b0}][TB_DEPTH-2:0], n[1]};
        end
    end

    // Strict compare so the lowest-index state wins a tie for best.
    always_comb begin
        pm_min = acs_pm[0];
        best   = 2'd0;
        for (int n = 1; n < 4; n++) begin
            if (acs_pm[n] < pm_min) begin
                pm_min = acs_pm[n];
                best   = 2'(n);
            end
        end
        for (int n = 0; n < 4; n++) begin
            pm_nxt[n] = acs_pm[n] - pm_min;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                pm[n]   <= (n == 0) ? 8'd0 : 8'd4;
                surv[n] <= '0;
            end
            sym_cnt     <= '0;
            dec_d_o     <= 1'b0;
            dec_valid_o <= 1'b0;
        end else begin
            dec_valid_o <= dec_enable_i && (sym_cnt >= CNT_VLD);
            if (dec_enable_i) begin
                for (int n = 0; n < 4; n++) begin
                    pm[n]   <= pm_nxt[n];
                    surv[n] <= surv_nxt[n];
                end
                dec_d_o <= surv_nxt[best][TB_DEPTH-1];
                if (sym_cnt != CNT_MAX) begin
                    sym_cnt <= sym_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_codec.sv
// Directed bench for viterbi_codec: encoder vector, warm-up, loopback with errors, gaps and async reset.
module tb_viterbi_codec;

    localparam int TB_DEPTH = 16;
    localparam int N_RAND   = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_enable_i = 1'b0;
    logic       enc_d_i = 1'b0;
    logic       enc_valid_o;
    logic [1:0] enc_d_o;
    logic       dec_enable_i = 1'b0;
    logic [1:0] dec_d_i = 2'b00;
    logic       dec_valid_o;
    logic       dec_d_o;

    viterbi_codec #(.TB_DEPTH(TB_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_enable_i (enc_enable_i),
        .enc_d_i      (enc_d_i),
        .enc_valid_o  (enc_valid_o),
        .enc_d_o      (enc_d_o),
        .dec_enable_i (dec_enable_i),
        .dec_d_i      (dec_d_i),
        .dec_valid_o  (dec_valid_o),
        .dec_d_o      (dec_d_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Bench-side reference state
    logic [1:0] enc_s;
    logic [1:0] exp_sym;
    logic       ch_vld;
    logic [1:0] ch_dat;
    int         dec_acc;
    int         dec_rd;
    int         sym_idx;
    logic       last_dec;
    logic       dec_known;
    logic       err_mode;
    logic       sent_q[$];
    logic       bits_mem[N_RAND];

    logic       vec_d  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] vec_sym[6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        enc_s     = 2'b00;
        exp_sym   = 2'b00;
        ch_vld    = 1'b0;
        ch_dat    = 2'b00;
        dec_acc   = 0;
        dec_rd    = 0;
        sym_idx   = 0;
        last_dec  = 1'b0;
        dec_known = 1'b1;
        err_mode  = 1'b0;
        sent_q.delete();
    endtask

    task automatic do_reset();
        enc_enable_i = 1'b0;
        dec_enable_i = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: drive encoder with (en,d), decoder from the 1-cycle channel register, then check.
    task automatic run_cycle(input logic en, input logic d);
        logic exp_dec_vld;
        logic acc;
        enc_enable_i = en;
        enc_d_i      = d;
        dec_enable_i = ch_vld;
        dec_d_i      = ch_dat;
        acc          = ch_vld;
        if (en) begin
            exp_sym = {d ^ enc_s[1] ^ enc_s[0], d ^ enc_s[0]};
            enc_s   = {d, enc_s[1]};
            sent_q.push_back(d);
        end
        exp_dec_vld = 1'b0;
        if (acc) begin
            dec_acc++;
            exp_dec_vld = (dec_acc >= TB_DEPTH);
        end
        @(posedge clk);
        #1;
        check("enc_vld", enc_valid_o, en);
        check("enc_sym", enc_d_o, exp_sym);
        check("dec_vld", dec_valid_o, exp_dec_vld);
        if (exp_dec_vld) begin
            if (dec_rd < sent_q.size()) begin
                check("dec_bit", dec_d_o, sent_q[dec_rd]);
                last_dec  = sent_q[dec_rd];
                dec_known = 1'b1;
            end else begin
                check("dec_overrun", dec_rd, sent_q.size());
            end
            dec_rd++;
        end else if (acc) begin
            dec_known = 1'b0;
        end else if (dec_known) begin
            check("dec_hold", dec_d_o, last_dec);
        end
        ch_vld = enc_valid_o;
        ch_dat = enc_d_o;
        if (enc_valid_o) begin
            if (err_mode && (sym_idx % 8 == 4)) ch_dat[0] = ~ch_dat[0];
            sym_idx++;
        end
    endtask

    task automatic run_stream(input int first, input int nbits, input logic gaps,
                              input logic errs, input logic flush);
        err_mode = errs;
        for (int i = 0; i < nbits; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) run_cycle(1'b0, 1'b0);
            run_cycle(1'b1, bits_mem[first + i]);
        end
        if (flush) begin
            run_cycle(1'b0, 1'b0);
            run_cycle(1'b0, 1'b0);
            check("n_decoded", dec_rd, nbits - (TB_DEPTH - 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N_RAND; i++) bits_mem[i] = 1'($urandom_range(0, 1));

        // Reset values
        do_reset();
        check("rst_enc_vld", enc_valid_o, 1'b0);
        check("rst_enc_sym", enc_d_o, 2'b00);
        check("rst_dec_vld", dec_valid_o, 1'b0);
        check("rst_dec_bit", dec_d_o, 1'b0);

        // Encoder directed vector 1,0,1,1,0,0 -> 11,10,00,01,01,11
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, vec_d[i]);
            check("enc_vec", enc_d_o, vec_sym[i]);
        end
        run_cycle(1'b0, 1'b0);
        check("enc_hold_sym", enc_d_o, 2'b11);
        check("enc_hold_vld", enc_valid_o, 1'b0);

        // Startup: TB_DEPTH-1 symbols never raise dec_valid_o
        do_reset();
        for (int i = 0; i < TB_DEPTH - 1; i++) begin
            run_cycle(1'b1, bits_mem[i]);
            check("startup_vld", dec_valid_o, 1'b0);
        end
        repeat (3) begin
            run_cycle(1'b0, 1'b0);
            check("startup_vld", dec_valid_o, 1'b0);
        end

        // Error-free loopback
        do_reset();
        run_stream(0, N_RAND, 1'b0, 1'b0, 1'b1);

        // One corrupted bit every 8 symbols
        do_reset();
        run_stream(0, 256, 1'b0, 1'b1, 1'b1);

        // Random enable gaps, same data as the gap-free run
        do_reset();
        run_stream(0, 300, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset after 40 symbols, then a fresh stream
        do_reset();
        run_stream(0, 40, 1'b0, 1'b0, 1'b0);
        enc_enable_i = 1'b0;
        dec_enable_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_enc_vld", enc_valid_o, 1'b0);
        check("arst_enc_sym", enc_d_o, 2'b00);
        check("arst_dec_vld", dec_valid_o, 1'b0);
        check("arst_dec_bit", dec_d_o, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_stream(100, 60, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
